branch_unit: RTL and testbench

- Parametrised branch decision and prediction unit for the pipelined MIPS datapath; the successor to the single-cycle beq/bne taken logic.
- Resolves six branch conditions (beq, bne, blez, bgtz, bltz, bgez) from ALU flags.
- Holds a table of 2-bit saturating counters indexed by PC, giving fetch a taken/not-taken prediction.
- Reports a registered resolved-taken result and a mispredict pulse, and keeps branch and mispredict statistics counters.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_unit_if.sv | 31 +++
 rtl/branch_cond.sv | 27 ++
 rtl/branch_unit.sv | 93 +++++++++
 tb/tb_branch_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: branch opcode encodings,
// 2-bit saturating counter states and the counter update rule.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_RSVD = 3'b111
  } br_op_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Move one step toward the resolved direction, holding at either end.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'b01;
    end
    return (ctr == SNT) ? SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Fetch-prediction and branch-resolution bus between the pipeline and the
// branch unit; the pipeline is the master, the branch unit the slave.
interface branch_unit_if #(
  parameter int CNT_W = 16
);

  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic [2:0]       res_op;
  logic             res_zero;
  logic             res_neg;
  logic             res_pred;
  logic             out_valid;
  logic             res_taken;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output pred_pc, res_valid, res_pc, res_op, res_zero, res_neg, res_pred,
    input  pred_taken, out_valid, res_taken, mispredict, branch_count, mispred_count
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, res_op, res_zero, res_neg, res_pred,
    output pred_taken, out_valid, res_taken, mispredict, branch_count, mispred_count
  );

endinterface

// File: rtl/branch_cond.sv
// Branch direction from opcode and ALU flags; also used standalone by the
// single-cycle datapath. 'live' is low for BR_NONE and BR_RSVD.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] op,
  input  logic       zero,
  input  logic       neg,
  output logic       taken,
  output logic       live
);

  always_comb begin
    taken = 1'b0;
    live  = 1'b1;
    case (op)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      BR_BLEZ: taken = zero | neg;
      BR_BGTZ: taken = ~zero & ~neg;
      BR_BLTZ: taken = neg;
      BR_BGEZ: taken = ~neg;
      default: live  = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// PC-indexed table of 2-bit saturating counters for fetch prediction, plus
// registered branch resolution, mispredict pulse and statistics counters.
module branch_unit
  import branch_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] INIT_CTR = WNT
) (
  input  logic             clk,
  input  logic             reset,
  branch_unit_if.slave     bus
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       ctr_q [DEPTH];
  logic [1:0]       ctr_d [DEPTH];
  logic             out_valid_q, out_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond_taken;
  logic             cond_live;
  logic             live;
  logic             unused_pc_bits;

  assign pred_idx = bus.pred_pc[IDX_W+1:2];
  assign res_idx  = bus.res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0],
                            bus.res_pc[31:IDX_W+2], bus.res_pc[1:0]};

  branch_cond u_cond (
    .op    (bus.res_op),
    .zero  (bus.res_zero),
    .neg   (bus.res_neg),
    .taken (cond_taken),
    .live  (cond_live)
  );

  assign live = bus.res_valid & cond_live;

  // Prediction reads the registered table, so a same-cycle update to the
  // same index is only visible from the following cycle.
  assign bus.pred_taken = ctr_q[pred_idx][1];

  always_comb begin
    ctr_d           = ctr_q;
    out_valid_d     = live;
    res_taken_d     = live & cond_taken;
    mispredict_d    = live & (cond_taken != bus.res_pred);
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (live) begin
      ctr_d[res_idx] = ctr_next(ctr_q[res_idx], cond_taken);
      branch_count_d = branch_count_q + CNT_W'(1);
      if (cond_taken != bus.res_pred) begin
        mispred_count_d = mispred_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= INIT_CTR;
      end
      out_valid_q     <= 1'b0;
      res_taken_q     <= 1'b0;
      mispredict_q    <= 1'b0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      ctr_q           <= ctr_d;
      out_valid_q     <= out_valid_d;
      res_taken_q     <= res_taken_d;
      mispredict_q    <= mispredict_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.res_taken     = res_taken_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.branch_count  = branch_count_q;
  assign bus.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed testbench for branch_unit: condition sweep, counter saturation,
// same-index collision, aliasing, ignored opcodes and mid-stream reset.
module tb_branch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  branch_unit_if #(.CNT_W(16)) bus ();

  branch_unit #(
    .IDX_W    (6),
    .CNT_W    (16),
    .INIT_CTR (2'b01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [2:0] op,
                               input logic z, input logic n, input logic pred);
    bus.res_valid = 1'b1;
    bus.res_pc    = pc;
    bus.res_op    = op;
    bus.res_zero  = z;
    bus.res_neg   = n;
    bus.res_pred  = pred;
  endtask

  // Advance past one rising edge, then drop the resolve request.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    bus.res_op    = 3'b000;
  endtask

  task automatic checkCounts(input string tag, input int br, input int mp);
    checkOutput({tag, "_branch_count"}, 32'(bus.branch_count), 32'(br));
    checkOutput({tag, "_mispred_count"}, 32'(bus.mispred_count), 32'(mp));
  endtask

  task automatic checkPred(input string tag, input logic [31:0] pc, input logic exp);
    bus.pred_pc = pc;
    #1;
    checkOutput(tag, 32'(bus.pred_taken), 32'(exp));
  endtask

  logic [2:0] sweep_op    [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  logic       sweep_z     [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       sweep_n     [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       sweep_taken [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       nt_pred     [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.pred_pc   = 32'h0040_0000;
    bus.res_valid = 1'b0;
    bus.res_pc    = 32'h0;
    bus.res_op    = 3'b000;
    bus.res_zero  = 1'b0;
    bus.res_neg   = 1'b0;
    bus.res_pred  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("rst_pred_taken", 32'(bus.pred_taken), 32'h0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_mispredict", 32'(bus.mispredict), 32'h0);
    checkCounts("rst", 0, 0);

    // Condition sweep; each op sees res_pred = 0
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'h10, sweep_op[i], sweep_z[i], sweep_n[i], 1'b0);
      stepCycle();
      checkOutput($sformatf("sweep%0d_out_valid", i), 32'(bus.out_valid), 32'h1);
      checkOutput($sformatf("sweep%0d_res_taken", i), 32'(bus.res_taken), 32'(sweep_taken[i]));
      checkOutput($sformatf("sweep%0d_mispredict", i), 32'(bus.mispredict), 32'(sweep_taken[i]));
    end
    stepCycle();
    checkOutput("idle_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("idle_res_taken", 32'(bus.res_taken), 32'h0);
    checkOutput("idle_mispredict", 32'(bus.mispredict), 32'h0);
    checkCounts("sweep", 6, 4);
    // idx 4 walked 01,10,01,10,11,10,11
    checkPred("sweep_pred_0x10", 32'h10, 1'b1);

    // Saturation at 0x20: up to 11 and back down to 00
    checkPred("sat_pred_init", 32'h20, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h20, 3'd1, 1'b1, 1'b0, 1'b0);
      stepCycle();
      checkOutput($sformatf("sat_up%0d_pred", i), 32'(bus.pred_taken), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h20, 3'd1, 1'b0, 1'b0, 1'b0);
      stepCycle();
      checkOutput($sformatf("sat_dn%0d_pred", i), 32'(bus.pred_taken), 32'(nt_pred[i]));
      checkOutput($sformatf("sat_dn%0d_mispredict", i), 32'(bus.mispredict), 32'h0);
    end
    applyStimulus(32'h20, 3'd1, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("sat_floor_pred", 32'(bus.pred_taken), 32'h0);
    checkCounts("sat", 15, 9);

    // Collision: ctr[8] = 01, read and taken update in the same cycle
    bus.pred_pc = 32'h20;
    applyStimulus(32'h20, 3'd1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("coll_pred_same_cycle", 32'(bus.pred_taken), 32'h0);
    stepCycle();
    checkOutput("coll_pred_next_cycle", 32'(bus.pred_taken), 32'h1);
    checkCounts("coll", 16, 10);

    // Aliasing: 0x100 maps to index 0; correct prediction, no mispredict
    checkPred("alias_pred_before", 32'h0, 1'b0);
    applyStimulus(32'h100, 3'd1, 1'b1, 1'b0, 1'b1);
    stepCycle();
    checkOutput("alias_res_taken", 32'(bus.res_taken), 32'h1);
    checkOutput("alias_mispredict", 32'(bus.mispredict), 32'h0);
    checkOutput("alias_pred_after", 32'(bus.pred_taken), 32'h1);
    checkPred("alias_low_bits", 32'h103, 1'b1);
    checkPred("alias_other_idx", 32'h40, 1'b0);

    // Reserved and none opcodes with flags that would mean taken for beq
    applyStimulus(32'h40, 3'd7, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rsvd_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rsvd_mispredict", 32'(bus.mispredict), 32'h0);
    applyStimulus(32'h40, 3'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("none_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("none_res_taken", 32'(bus.res_taken), 32'h0);
    checkPred("ignored_pred_0x40", 32'h40, 1'b0);
    checkCounts("ignored", 17, 10);

    // Reset together with a live mispredicting bne
    applyStimulus(32'h10, 3'd2, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midrst_mispredict", 32'(bus.mispredict), 32'h0);
    checkOutput("midrst_res_taken", 32'(bus.res_taken), 32'h0);
    checkCounts("midrst", 0, 0);
    for (int i = 0; i < 64; i++) begin
      checkPred($sformatf("midrst_pred_idx%0d", i), 32'(i * 4), 1'b0);
    end
    // One taken step from 01 must reach 10
    applyStimulus(32'h10, 3'd1, 1'b1, 1'b0, 1'b1);
    stepCycle();
    checkPred("midrst_init_ctr", 32'h10, 1'b1);
    checkCounts("post_rst", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
